// File: rtl/bird_launcher.sv
// Slingshot front-end: turns aim/fire keys into one registered launch strobe
// with latched angle and power. Re-fire is blocked while a bird is in flight
// and for a cooldown period after the flight ends.
//
// Launch strobe protocol: shoot_bird_pulse is high for exactly one clk, the
// clk that follows the one in which key_fire was seen low during CHARGE.
// launch_angle and launch_power are valid in that clk and stay held through
// FLIGHT. There is no back-pressure; consumers must sample the strobe.
module bird_launcher #(
    parameter int unsigned ANGLE_MAX       = 8,
    parameter int unsigned ANGLE_DEFAULT   = 4,
    parameter int unsigned POWER_MAX       = 15,
    parameter int unsigned CHARGE_FRAMES   = 2,
    parameter int unsigned FLIGHT_TIMEOUT  = 240,
    parameter int unsigned COOLDOWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startGame,
    input  logic       newLevelPulse,
    input  logic [3:0] birdsLeft,
    input  logic       bird_active,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_fire,
    output logic       shoot_bird_pulse,
    output logic [3:0] launch_angle,
    output logic [3:0] launch_power,
    output logic       charging,
    output logic [2:0] launcher_state
);

    typedef enum logic [2:0] {
        DISABLED = 3'd0,
        READY    = 3'd1,
        CHARGE   = 3'd2,
        FIRE     = 3'd3,
        FLIGHT   = 3'd4,
        COOLDOWN = 3'd5
    } state_t;

    localparam logic [3:0] ANGLE_MAX_L  = ANGLE_MAX[3:0];
    localparam logic [3:0] ANGLE_DEF_L  = ANGLE_DEFAULT[3:0];
    localparam logic [3:0] POWER_MAX_L  = POWER_MAX[3:0];
    localparam logic [7:0] CHARGE_LAST  = 8'(CHARGE_FRAMES - 1);
    localparam logic [7:0] FLIGHT_LAST  = 8'(FLIGHT_TIMEOUT - 1);
    localparam logic [7:0] COOL_LAST    = 8'(COOLDOWN_FRAMES - 1);

    state_t     state, state_nx;
    logic [3:0] angle_nx, power_nx;
    logic [7:0] cnt, cnt_nx;
    logic       seen, seen_nx;
    logic       fire_d;
    logic       fire_rise;

    // A new press is a rising edge; a fire still held from before needs a release first.
    assign fire_rise      = key_fire & ~fire_d;
    assign launcher_state = state;

    // Next-state, aim/charge arithmetic and frame counting, in priority order.
    always_comb begin
        state_nx = state;
        angle_nx = launch_angle;
        power_nx = launch_power;
        cnt_nx   = cnt;
        seen_nx  = seen;
        if (!startGame) begin
            state_nx = DISABLED;
            power_nx = 4'd0;
            cnt_nx   = 8'd0;
        end else if (newLevelPulse) begin
            state_nx = COOLDOWN;
            angle_nx = ANGLE_DEF_L;
            power_nx = 4'd0;
            cnt_nx   = 8'd0;
        end else begin
            case (state)
                DISABLED: begin
                    state_nx = READY;
                    angle_nx = ANGLE_DEF_L;
                    cnt_nx   = 8'd0;
                end
                READY: begin
                    if (startOfFrame) begin
                        if (key_up && !key_down && (launch_angle < ANGLE_MAX_L))
                            angle_nx = launch_angle + 4'd1;
                        else if (key_down && !key_up && (launch_angle != 4'd0))
                            angle_nx = launch_angle - 4'd1;
                    end
                    if (fire_rise && (birdsLeft != 4'd0)) begin
                        state_nx = CHARGE;
                        power_nx = 4'd1;
                        cnt_nx   = 8'd0;
                    end
                end
                CHARGE: begin
                    // Release wins over a power step landing in the same clk.
                    if (!key_fire) begin
                        state_nx = FIRE;
                        cnt_nx   = 8'd0;
                    end else if (startOfFrame) begin
                        if (cnt == CHARGE_LAST) begin
                            cnt_nx = 8'd0;
                            if (launch_power < POWER_MAX_L)
                                power_nx = launch_power + 4'd1;
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end
                end
                FIRE: begin
                    state_nx = FLIGHT;
                    cnt_nx   = 8'd0;
                    seen_nx  = 1'b0;
                end
                FLIGHT: begin
                    // Flight ends when the bird has appeared and vanished, or on timeout.
                    if (bird_active)
                        seen_nx = 1'b1;
                    if (startOfFrame) begin
                        if ((seen && !bird_active) || (cnt == FLIGHT_LAST)) begin
                            state_nx = COOLDOWN;
                            power_nx = 4'd0;
                            cnt_nx   = 8'd0;
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (startOfFrame) begin
                        if (cnt == COOL_LAST) begin
                            state_nx = READY;
                            cnt_nx   = 8'd0;
                        end else begin
                            cnt_nx = cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state_nx = DISABLED;
                    power_nx = 4'd0;
                    cnt_nx   = 8'd0;
                end
            endcase
        end
    end

    // State, datapath and registered outputs; strobe/charging follow the next state.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state            <= DISABLED;
            launch_angle     <= ANGLE_DEF_L;
            launch_power     <= 4'd0;
            cnt              <= 8'd0;
            seen             <= 1'b0;
            fire_d           <= 1'b0;
            shoot_bird_pulse <= 1'b0;
            charging         <= 1'b0;
        end else begin
            state            <= state_nx;
            launch_angle     <= angle_nx;
            launch_power     <= power_nx;
            cnt              <= cnt_nx;
            seen             <= seen_nx;
            fire_d           <= key_fire;
            shoot_bird_pulse <= (state_nx == FIRE);
            charging         <= (state_nx == CHARGE);
        end
    end

endmodule

// File: tb/tb_bird_launcher.sv
// Bench for bird_launcher: directed scenarios plus random play, every cycle
// compared against a frame-counting behavioural model.
module tb_bird_launcher;

    localparam int ADEF = 4;
    localparam int AMAX = 8;
    localparam int PMAX = 15;
    localparam int CF   = 2;
    localparam int FT   = 240;
    localparam int CD   = 30;
    localparam int FP   = 4;   // clocks per frame

    localparam int S_DIS = 0, S_RDY = 1, S_CHG = 2, S_FIRE = 3, S_FLT = 4, S_CD = 5;

    logic       clk = 0;
    logic       resetN = 1;
    logic       startOfFrame = 0;
    logic       startGame = 0;
    logic       newLevelPulse = 0;
    logic [3:0] birdsLeft = 4'd3;
    logic       bird_active = 0;
    logic       key_up = 0;
    logic       key_down = 0;
    logic       key_fire = 0;
    logic       shoot_bird_pulse;
    logic [3:0] launch_angle;
    logic [3:0] launch_power;
    logic       charging;
    logic [2:0] launcher_state;

    int checks = 0;
    int errors = 0;
    int n_pulses = 0;
    int cyc = 0;
    logic [7:0] exp_q[$];

    bird_launcher dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startGame(startGame),
        .newLevelPulse(newLevelPulse), .birdsLeft(birdsLeft), .bird_active(bird_active),
        .key_up(key_up), .key_down(key_down), .key_fire(key_fire),
        .shoot_bird_pulse(shoot_bird_pulse), .launch_angle(launch_angle),
        .launch_power(launch_power), .charging(charging), .launcher_state(launcher_state)
    );

    // Clock and frame strobe
    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        startOfFrame = ((cyc % FP) == 0);
    end

    // Behavioural model: tracks mode and frames spent in it; power is derived
    // from frames charged rather than stepped.
    int m_state = S_DIS, m_angle = ADEF, m_power = 0, m_frames = 0;
    bit m_seen = 0, m_fire_d = 0, m_pulse = 0;
    int nxt;
    bit rise, enter;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_state = S_DIS; m_angle = ADEF; m_power = 0; m_frames = 0;
            m_seen = 0; m_fire_d = 0; m_pulse = 0;
        end else begin
            rise = key_fire && !m_fire_d;
            m_fire_d = key_fire;
            nxt = m_state;
            enter = 0;
            if (!startGame) begin
                nxt = S_DIS; enter = 1; m_power = 0;
            end else if (newLevelPulse) begin
                nxt = S_CD; enter = 1; m_angle = ADEF; m_power = 0;
            end else begin
                case (m_state)
                    S_DIS: begin nxt = S_RDY; enter = 1; m_angle = ADEF; end
                    S_RDY: begin
                        if (startOfFrame) begin
                            if (key_up && !key_down) m_angle = (m_angle < AMAX) ? m_angle + 1 : m_angle;
                            else if (key_down && !key_up) m_angle = (m_angle > 0) ? m_angle - 1 : 0;
                        end
                        if (rise && birdsLeft != 0) begin nxt = S_CHG; enter = 1; end
                    end
                    S_CHG: begin
                        if (!key_fire) begin
                            nxt = S_FIRE; enter = 1;
                        end else if (startOfFrame) begin
                            m_frames++;
                            m_power = (1 + m_frames / CF > PMAX) ? PMAX : 1 + m_frames / CF;
                        end
                    end
                    S_FIRE: begin nxt = S_FLT; enter = 1; end
                    S_FLT: begin
                        if (startOfFrame) begin
                            m_frames++;
                            if (m_frames == FT || (m_seen && !bird_active)) begin nxt = S_CD; enter = 1; end
                        end
                        if (bird_active) m_seen = 1;
                    end
                    S_CD: begin
                        if (startOfFrame) begin
                            m_frames++;
                            if (m_frames == CD) begin nxt = S_RDY; enter = 1; end
                        end
                    end
                    default: nxt = S_DIS;
                endcase
            end
            if (enter) begin
                m_frames = 0;
                if (nxt == S_CHG) m_power = 1;
                if (nxt == S_CD)  m_power = 0;
                if (nxt == S_FLT) m_seen = 0;
            end
            m_pulse = (nxt == S_FIRE);
            m_state = nxt;
        end
    end

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
        end
    endtask

    // Per-cycle compare against the model, plus launch scoreboard
    always @(negedge clk) begin
        cmp("state", int'(launcher_state), m_state);
        cmp("angle", int'(launch_angle), m_angle);
        cmp("power", int'(launch_power), m_power);
        cmp("charging", int'(charging), (m_state == S_CHG) ? 1 : 0);
        cmp("pulse", int'(shoot_bird_pulse), int'(m_pulse));
        if (m_pulse) exp_q.push_back({4'(m_angle), 4'(m_power)});
        if (shoot_bird_pulse) begin
            n_pulses++;
            if (exp_q.size() == 0) cmp("unexpected_launch", 1, 0);
            else cmp("launch_data", int'({launch_angle, launch_power}), int'(exp_q.pop_front()));
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!startOfFrame) @(posedge clk);
        end
        #1;
    endtask

    // Literal expectation pinned on both DUT and model
    task automatic lit(input string nm, input int dut_v, input int mdl_v, input int exp);
        cmp({nm, "_dut"}, dut_v, exp);
        cmp({nm, "_model"}, mdl_v, exp);
    endtask

    int p0;

    initial begin
        #2 resetN = 0;
        tick(2);
        lit("reset_state", int'(launcher_state), m_state, S_DIS);
        lit("reset_angle", int'(launch_angle), m_angle, ADEF);
        lit("reset_power", int'(launch_power), m_power, 0);
        resetN = 1;

        // Aim up, then saturate at the top
        startGame = 1;
        tick(1);
        lit("game_start", int'(launcher_state), m_state, S_RDY);
        key_up = 1;
        wait_frames(3);
        lit("angle_up3", int'(launch_angle), m_angle, 7);
        wait_frames(3);
        lit("angle_sat", int'(launch_angle), m_angle, 8);
        key_up = 0;

        // Charge 10 frames, release, single strobe one clk later
        p0 = n_pulses;
        key_fire = 1;
        tick(1);
        wait_frames(10);
        lit("charge10_power", int'(launch_power), m_power, 6);
        key_fire = 0;
        tick(1);
        lit("fire_pulse", int'(shoot_bird_pulse), int'(m_pulse), 1);
        lit("fire_angle", int'(launch_angle), m_angle, 8);
        tick(1);
        lit("pulse_once", n_pulses - p0, n_pulses - p0, 1);
        lit("flight", int'(launcher_state), m_state, S_FLT);

        // Flight ended by the bird; presses during flight/cooldown ignored
        bird_active = 1;
        key_fire = 1; tick(2); key_fire = 0;
        wait_frames(5);
        bird_active = 0;
        wait_frames(1);
        lit("flight_end", int'(launcher_state), m_state, S_CD);
        key_fire = 1; wait_frames(2);
        key_fire = 0; wait_frames(2);
        key_fire = 1; wait_frames(25);
        lit("cooldown_29", int'(launcher_state), m_state, S_CD);
        wait_frames(1);
        lit("cooldown_done", int'(launcher_state), m_state, S_RDY);
        tick(3);
        lit("held_no_rise", int'(launcher_state), m_state, S_RDY);
        lit("no_extra_pulse", n_pulses - p0, n_pulses - p0, 1);
        key_fire = 0;
        tick(1);

        // Power saturation, then flight timeout with no bird seen
        key_fire = 1;
        tick(1);
        wait_frames(40);
        lit("power_sat", int'(launch_power), m_power, 15);
        key_fire = 0;
        tick(1);
        lit("sat_pulse_power", int'(launch_power), m_power, 15);
        tick(1);
        wait_frames(239);
        lit("timeout_239", int'(launcher_state), m_state, S_FLT);
        wait_frames(1);
        lit("timeout_240", int'(launcher_state), m_state, S_CD);
        wait_frames(CD);
        lit("ready_again", int'(launcher_state), m_state, S_RDY);

        // No birds left: press ignored
        p0 = n_pulses;
        birdsLeft = 0;
        key_fire = 1;
        tick(3);
        lit("no_birds", int'(launcher_state), m_state, S_RDY);
        key_fire = 0;
        birdsLeft = 3;
        tick(1);

        // New level aborts a charge; game stop disables
        key_fire = 1;
        tick(1);
        wait_frames(3);
        newLevelPulse = 1;
        tick(1);
        newLevelPulse = 0;
        lit("newlvl_state", int'(launcher_state), m_state, S_CD);
        lit("newlvl_angle", int'(launch_angle), m_angle, ADEF);
        key_fire = 0;
        tick(2);
        lit("newlvl_nopulse", n_pulses - p0, n_pulses - p0, 0);
        startGame = 0;
        tick(1);
        lit("game_stop", int'(launcher_state), m_state, S_DIS);

        // Asynchronous reset in the middle of a charge
        startGame = 1;
        tick(1);
        key_fire = 1;
        tick(1);
        resetN = 0;
        #1;
        lit("async_rst_state", int'(launcher_state), m_state, S_DIS);
        lit("async_rst_power", int'(launch_power), m_power, 0);
        key_fire = 0;
        tick(2);
        resetN = 1;
        tick(1);

        // Random play
        for (int i = 0; i < 4000; i++) begin
            startGame     = ($urandom_range(0, 199) != 0);
            newLevelPulse = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) birdsLeft = 4'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) key_up = ~key_up;
            if ($urandom_range(0, 7) == 0) key_down = ~key_down;
            if ($urandom_range(0, 15) == 0) key_fire = ~key_fire;
            if ($urandom_range(0, 19) == 0) bird_active = ~bird_active;
            tick(1);
        end
        tick(2);
        cmp("launch_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
